// File: rtl/bsg_mesh_pkt_tracker_pkg.sv
// Shared types and width helpers for the mesh packet tracker.
// Every tracker file imports this package.
package bsg_mesh_pkt_tracker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_SAMPLED = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERR     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_MISMATCH  = 2'd0,
        ERR_UNDERFLOW = 2'd1,
        ERR_OVERFLOW  = 2'd2,
        ERR_TIMEOUT   = 2'd3
    } err_code_e;

    function automatic int cord_w(input int x_w, input int y_w);
        return x_w + y_w;
    endfunction

    function automatic int pkt_w(input int x_w, input int y_w, input int data_w);
        return 2 * cord_w(x_w, y_w) + data_w;
    endfunction

endpackage

// File: rtl/bsg_mesh_pkt_tracker_chan.sv
// One watch channel: counts same-path packets ahead of the watched packet and
// checks that the watched packet is the next one delivered on that path.
module bsg_mesh_pkt_tracker_chan
    import bsg_mesh_pkt_tracker_pkg::*;
#(
    parameter int DATA_WIDTH_P = 4,
    parameter int CORD_W       = 2,
    parameter int CNT_WIDTH_P  = 4,
    parameter int TIMEOUT_P    = 64
)(
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             i_watch_v,
    input  logic [CORD_W-1:0]                i_watch_src,
    input  logic [DATA_WIDTH_P+CORD_W-1:0]   i_watch_pkt,
    input  logic                             i_watch_clear,
    input  logic                             i_inj_v,
    input  logic [2*CORD_W+DATA_WIDTH_P-1:0] i_inj_pkt,
    input  logic                             i_ej_v,
    input  logic [2*CORD_W+DATA_WIDTH_P-1:0] i_ej_pkt,
    output logic [CORD_W-1:0]                o_src,
    output logic [CORD_W-1:0]                o_dest,
    output logic                             o_watch_ready,
    output logic                             o_done,
    output logic                             o_err,
    output logic [1:0]                       o_err_code,
    output logic [CNT_WIDTH_P-1:0]           o_cnt
);

    localparam int WPKT_W = DATA_WIDTH_P + CORD_W;
    localparam int PKT_W  = WPKT_W + CORD_W;
    localparam int TMR_W  = (TIMEOUT_P > 1) ? $clog2(TIMEOUT_P) : 1;

    localparam logic [CNT_WIDTH_P-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH_P-1:0] CNT_ONE  = CNT_WIDTH_P'(1);
    localparam logic [TMR_W-1:0]       TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0]       TMR_LAST = TMR_W'(TIMEOUT_P - 1);

    state_e                  r_state;
    err_code_e               r_err_code;
    logic [CORD_W-1:0]       r_src;
    logic [WPKT_W-1:0]       r_pkt;
    logic [CNT_WIDTH_P-1:0]  r_cnt;
    logic [TMR_W-1:0]        r_tmr;
    logic                    r_ready;
    logic                    r_done;
    logic                    r_err;

    logic w_inj_hit;
    logic w_inj_sample;
    logic w_inj_inc;
    logic w_ej_hit;
    logic w_ej_zero;
    logic w_ej_dec;
    logic w_ej_pkt_eq;

    // Injections carry their own source in the header; only src->dest traffic counts.
    assign w_inj_hit    = i_inj_v
                       && (i_inj_pkt[PKT_W-1 -: CORD_W] == r_src)
                       && (i_inj_pkt[CORD_W-1:0] == r_pkt[CORD_W-1:0]);
    assign w_inj_sample = w_inj_hit && (i_inj_pkt[WPKT_W-1:0] == r_pkt);
    assign w_inj_inc    = w_inj_hit && !w_inj_sample;

    assign w_ej_hit     = i_ej_v && (i_ej_pkt[PKT_W-1 -: CORD_W] == r_src);
    assign w_ej_zero    = w_ej_hit && (r_cnt == '0);
    assign w_ej_dec     = w_ej_hit && (r_cnt != '0);
    assign w_ej_pkt_eq  = (i_ej_pkt[WPKT_W-1:0] == r_pkt);

    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && i_watch_v) begin
            r_src <= i_watch_src;
            r_pkt <= i_watch_pkt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_tmr      <= '0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_MISMATCH;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_watch_v) begin
                        r_state <= ST_ARMED;
                        r_cnt   <= '0;
                        r_tmr   <= '0;
                        r_ready <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (w_ej_zero) begin
                        r_state    <= ST_ERR;
                        r_err      <= 1'b1;
                        r_err_code <= ERR_UNDERFLOW;
                    end else if (w_inj_inc && !w_ej_dec && r_cnt == CNT_MAX) begin
                        r_state    <= ST_ERR;
                        r_err      <= 1'b1;
                        r_err_code <= ERR_OVERFLOW;
                    end else begin
                        // Simultaneous increment and decrement cancel out.
                        if (w_inj_inc && !w_ej_dec) begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end else if (w_ej_dec && !w_inj_inc) begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                        if (w_inj_sample) begin
                            r_state <= ST_SAMPLED;
                        end
                    end
                end
                ST_SAMPLED: begin
                    r_tmr <= r_tmr + TMR_ONE;
                    if (w_ej_zero) begin
                        if (w_ej_pkt_eq) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= ST_ERR;
                            r_err      <= 1'b1;
                            r_err_code <= ERR_MISMATCH;
                        end
                    end else begin
                        if (w_ej_dec) begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                        if (r_tmr == TMR_LAST) begin
                            r_state    <= ST_ERR;
                            r_err      <= 1'b1;
                            r_err_code <= ERR_TIMEOUT;
                        end
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (i_watch_clear) begin
                        r_state    <= ST_IDLE;
                        r_cnt      <= '0;
                        r_tmr      <= '0;
                        r_ready    <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_err_code <= ERR_MISMATCH;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_src         = r_src;
    assign o_dest        = r_pkt[CORD_W-1:0];
    assign o_watch_ready = r_ready;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_err_code    = r_err_code;
    assign o_cnt         = r_cnt;

endmodule

// File: rtl/bsg_mesh_pkt_tracker.sv
// Mesh packet tracker: CHANNELS_P independent watchers, each steered to the
// injection port of its source node and the ejection port of its destination.
module bsg_mesh_pkt_tracker
    import bsg_mesh_pkt_tracker_pkg::*;
#(
    parameter int  DATA_WIDTH_P   = 4,
    parameter int  X_CORD_WIDTH_P = 1,
    parameter int  Y_CORD_WIDTH_P = 1,
    parameter int  CHANNELS_P     = 2,
    parameter int  CNT_WIDTH_P    = 4,
    parameter int  TIMEOUT_P      = 64,
    localparam int CORD_W         = cord_w(X_CORD_WIDTH_P, Y_CORD_WIDTH_P),
    localparam int N              = 1 << CORD_W,
    localparam int PKT_W          = pkt_w(X_CORD_WIDTH_P, Y_CORD_WIDTH_P, DATA_WIDTH_P)
)(
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic [N-1:0]                                 inj_v_i,
    input  logic [N-1:0]                                 inj_yumi_i,
    input  logic [N-1:0][PKT_W-1:0]                      inj_data_i,
    input  logic [N-1:0]                                 ej_v_i,
    input  logic [N-1:0]                                 ej_ready_and_i,
    input  logic [N-1:0][PKT_W-1:0]                      ej_data_i,
    input  logic [CHANNELS_P-1:0]                        watch_v_i,
    output logic [CHANNELS_P-1:0]                        watch_ready_o,
    input  logic [CHANNELS_P-1:0][CORD_W-1:0]            watch_src_i,
    input  logic [CHANNELS_P-1:0][DATA_WIDTH_P+CORD_W-1:0] watch_pkt_i,
    input  logic [CHANNELS_P-1:0]                        watch_clear_i,
    output logic [CHANNELS_P-1:0]                        done_o,
    output logic [CHANNELS_P-1:0]                        err_o,
    output logic [CHANNELS_P-1:0][1:0]                   err_code_o,
    output logic [CHANNELS_P-1:0][CNT_WIDTH_P-1:0]       cnt_o
);

    for (genvar c = 0; c < CHANNELS_P; c++) begin : g_chan
        logic [CORD_W-1:0] w_src;
        logic [CORD_W-1:0] w_dest;

        // Node index is the {y,x} coordinate, so coordinates select ports directly.
        bsg_mesh_pkt_tracker_chan #(
            .DATA_WIDTH_P (DATA_WIDTH_P),
            .CORD_W       (CORD_W),
            .CNT_WIDTH_P  (CNT_WIDTH_P),
            .TIMEOUT_P    (TIMEOUT_P)
        ) u_chan (
            .clk           (clk),
            .reset_n       (reset_n),
            .i_watch_v     (watch_v_i[c]),
            .i_watch_src   (watch_src_i[c]),
            .i_watch_pkt   (watch_pkt_i[c]),
            .i_watch_clear (watch_clear_i[c]),
            .i_inj_v       (inj_v_i[w_src] & inj_yumi_i[w_src]),
            .i_inj_pkt     (inj_data_i[w_src]),
            .i_ej_v        (ej_v_i[w_dest] & ej_ready_and_i[w_dest]),
            .i_ej_pkt      (ej_data_i[w_dest]),
            .o_src         (w_src),
            .o_dest        (w_dest),
            .o_watch_ready (watch_ready_o[c]),
            .o_done        (done_o[c]),
            .o_err         (err_o[c]),
            .o_err_code    (err_code_o[c]),
            .o_cnt         (cnt_o[c])
        );
    end

endmodule
